// File: rtl/kianv_bus_bridge.sv
// Memory-side bridge for the kianV core: routes valid/ready requests to SRAM or req/ack MMIO.
// Optional MMIO timeout is compiled in with `define KIANV_BUS_TIMEOUT_EN.
module kianv_bus_bridge #(
    parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
    parameter int          RAM_AW         = 10,
    parameter logic [31:0] MMIO_BASE      = 32'h1000_0000,
    parameter logic [31:0] MMIO_MASK      = 32'hF000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              ram_ce,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_req,
    output logic [3:0]        io_wstrb,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic              io_ack,
    input  logic [31:0]       io_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_RD  = 2'd1,
        IO_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [31:0] RAM_MASK = ~((32'd1 << (RAM_AW + 2)) - 32'd1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_reg, state_next;
    logic [31:0] resp_reg, resp_next;
    logic        err_reg, err_next;
    logic        ready_reg, bus_err_reg;
    logic        io_req_reg, io_req_next;
    logic [3:0]  io_wstrb_reg, io_wstrb_next;
    logic [31:0] io_addr_reg, io_addr_next;
    logic [31:0] io_wdata_reg, io_wdata_next;

    logic ram_hit, io_hit;

`ifdef KIANV_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

    assign ram_hit = (mem_addr & RAM_MASK) == RAM_BASE;
    assign io_hit  = (mem_addr & MMIO_MASK) == MMIO_BASE;

    always_comb begin
        state_next    = state_reg;
        resp_next     = resp_reg;
        err_next      = err_reg;
        io_req_next   = io_req_reg;
        io_wstrb_next = io_wstrb_reg;
        io_addr_next  = io_addr_reg;
        io_wdata_next = io_wdata_reg;
        ram_ce        = 1'b0;
        ram_we        = 4'b0000;
        ram_addr      = mem_addr[RAM_AW+1:2];
        ram_wdata     = mem_wdata;
`ifdef KIANV_BUS_TIMEOUT_EN
        cnt_next      = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (mem_valid) begin
                    err_next = 1'b0;
                    // RAM wins when a request also falls in the MMIO window.
                    if (ram_hit) begin
                        ram_ce     = 1'b1;
                        ram_we     = mem_wstrb;
                        state_next = (|mem_wstrb) ? DONE : RAM_RD;
                    end else if (io_hit) begin
                        io_req_next   = 1'b1;
                        io_wstrb_next = mem_wstrb;
                        io_addr_next  = mem_addr;
                        io_wdata_next = mem_wdata;
                        state_next    = IO_WAIT;
`ifdef KIANV_BUS_TIMEOUT_EN
                        cnt_next      = '0;
`endif
                    end else begin
                        resp_next  = 32'h0000_0000;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            RAM_RD: begin
                resp_next  = ram_rdata;
                state_next = DONE;
            end
            IO_WAIT: begin
                if (io_ack) begin
                    io_req_next = 1'b0;
                    resp_next   = io_rdata;
                    state_next  = DONE;
                end
`ifdef KIANV_BUS_TIMEOUT_EN
                // This cycle is the last permitted wait; an ack in it still wins above.
                else if (cnt_reg == CNT_LAST) begin
                    io_req_next = 1'b0;
                    resp_next   = 32'hFFFF_FFFF;
                    err_next    = 1'b1;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            resp_reg     <= 32'h0000_0000;
            err_reg      <= 1'b0;
            ready_reg    <= 1'b0;
            bus_err_reg  <= 1'b0;
            io_req_reg   <= 1'b0;
            io_wstrb_reg <= 4'b0000;
            io_addr_reg  <= 32'h0000_0000;
            io_wdata_reg <= 32'h0000_0000;
`ifdef KIANV_BUS_TIMEOUT_EN
            cnt_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            resp_reg     <= resp_next;
            err_reg      <= err_next;
            ready_reg    <= (state_next == DONE);
            bus_err_reg  <= (state_next == DONE) && err_next;
            io_req_reg   <= io_req_next;
            io_wstrb_reg <= io_wstrb_next;
            io_addr_reg  <= io_addr_next;
            io_wdata_reg <= io_wdata_next;
`ifdef KIANV_BUS_TIMEOUT_EN
            cnt_reg      <= cnt_next;
`endif
        end
    end

    assign mem_ready = ready_reg;
    assign bus_err   = bus_err_reg;
    assign mem_rdata = resp_reg;
    assign io_req    = io_req_reg;
    assign io_wstrb  = io_wstrb_reg;
    assign io_addr   = io_addr_reg;
    assign io_wdata  = io_wdata_reg;

endmodule

// File: tb/tb_kianv_bus_bridge.sv
// Directed bench for kianv_bus_bridge with a small SRAM model and a hand-driven MMIO port.
`timescale 1ns/1ps
module tb_kianv_bus_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [3:0]  mem_wstrb = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        ram_ce;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        io_req;
    logic [3:0]  io_wstrb;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_ack = 1'b0;
    logic [31:0] io_rdata = 32'h0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

`ifdef KIANV_BUS_TIMEOUT_EN
    localparam int ACK_DLY = 3;
`else
    localparam int ACK_DLY = 5;
`endif

    kianv_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_req(io_req), .io_wstrb(io_wstrb), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model: read-before-write, data valid the cycle after ram_ce.
    logic [31:0] sram [0:1023];
    always @(posedge clk) begin
        if (ram_ce) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= sram[ram_addr];
        end
    end

    // Begin a request; returns inside cycle T, after combinational settling.
    task automatic start(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        #1;
    endtask

    // Wait for mem_ready; lat = cycles after T, or -1 when the budget expires.
    task automatic wait_ready(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat = i;
                break;
            end
        end
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({mem_ready, bus_err, io_req, ram_ce} !== 4'b0000 || mem_rdata !== 32'h0 ||
            io_addr !== 32'h0 || io_wdata !== 32'h0 || io_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b err=%b io_req=%b ce=%b rdata=%h io_addr=%h, required all zero",
                     mem_ready, bus_err, io_req, ram_ce, mem_rdata, io_addr);
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_ram_write_read();
        int lat;
        start(32'h0000_0010, 32'hA5A5_1234, 4'hF);
        checks++;
        if (ram_ce !== 1'b1 || ram_we !== 4'hF || ram_addr !== 10'd4 || ram_wdata !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL ram_wr_drive: ce=%b we=%h addr=%0d wdata=%h, required 1 f 4 a5a51234",
                     ram_ce, ram_we, ram_addr, ram_wdata);
        end
        wait_ready(10, lat);
        checks++;
        if (lat !== 1 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL ram_wr_latency: lat=%0d err=%b, required 1 0", lat, bus_err);
        end
        $display("ram write 0x10: lat=%0d", lat);
        // Issued in the cycle after DONE: back-to-back read of the same word.
        start(32'h0000_0010, 32'h0, 4'h0);
        checks++;
        if (ram_ce !== 1'b1 || ram_we !== 4'h0 || ram_addr !== 10'd4) begin
            errors++;
            $display("FAIL ram_rd_drive: ce=%b we=%h addr=%0d, required 1 0 4", ram_ce, ram_we, ram_addr);
        end
        wait_ready(10, lat);
        checks++;
        if (lat !== 2 || mem_rdata !== 32'hA5A5_1234 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL ram_rd: lat=%0d rdata=%h err=%b, required 2 a5a51234 0", lat, mem_rdata, bus_err);
        end
        $display("ram read 0x10: lat=%0d rdata=%h", lat, mem_rdata);
    endtask

    task automatic test_byte_write();
        int lat;
        start(32'h0000_0020, 32'h0000_0000, 4'hF);
        wait_ready(10, lat);
        start(32'h0000_0022, 32'h1122_3344, 4'b0100);
        checks++;
        if (ram_ce !== 1'b1 || ram_we !== 4'b0100 || ram_addr !== 10'd8) begin
            errors++;
            $display("FAIL byte_wr_drive: ce=%b we=%b addr=%0d, required 1 0100 8", ram_ce, ram_we, ram_addr);
        end
        wait_ready(10, lat);
        @(posedge clk); #1;
        checks++;
        if (lat !== 1 || mem_ready !== 1'b0 || ram_ce !== 1'b0) begin
            errors++;
            $display("FAIL byte_wr_pulse: lat=%0d ready_after=%b ce_after=%b, required 1 0 0", lat, mem_ready, ram_ce);
        end
        start(32'h0000_0020, 32'h0, 4'h0);
        wait_ready(10, lat);
        checks++;
        if (lat !== 2 || mem_rdata !== 32'h0022_0000) begin
            errors++;
            $display("FAIL byte_wr_readback: lat=%0d rdata=%h, required 2 00220000", lat, mem_rdata);
        end
        $display("byte write 0x22: readback=%h", mem_rdata);
    endtask

    task automatic test_mmio_read();
        int bad = 0;
        start(32'h1000_0004, 32'h0, 4'h0);
        checks++;
        if (ram_ce !== 1'b0 || io_req !== 1'b0) begin
            errors++;
            $display("FAIL mmio_issue: ce=%b io_req=%b at T, required 0 0", ram_ce, io_req);
        end
        for (int i = 1; i <= ACK_DLY; i++) begin
            @(posedge clk); #1;
            if (io_req !== 1'b1 || mem_ready !== 1'b0 || io_addr !== 32'h1000_0004 || io_wstrb !== 4'h0) bad++;
            if (i == ACK_DLY) begin
                io_ack = 1'b1; io_rdata = 32'hCAFE_F00D;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mmio_wait: %0d bad wait cycles, required 0", bad);
        end
        @(posedge clk); #1;
        io_ack = 1'b0; io_rdata = 32'h0;
        mem_valid = 1'b0;
        checks++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'hCAFE_F00D || bus_err !== 1'b0 || io_req !== 1'b0) begin
            errors++;
            $display("FAIL mmio_rd: ready=%b rdata=%h err=%b io_req=%b, required 1 cafef00d 0 0",
                     mem_ready, mem_rdata, bus_err, io_req);
        end
        $display("mmio read 0x10000004: rdata=%h", mem_rdata);
    endtask

    task automatic test_mmio_write_min();
        int lat;
        start(32'h1000_0100, 32'hDEAD_BEEF, 4'b0011);
        @(posedge clk); #1;
        checks++;
        if (io_req !== 1'b1 || io_addr !== 32'h1000_0100 || io_wdata !== 32'hDEAD_BEEF || io_wstrb !== 4'b0011) begin
            errors++;
            $display("FAIL mmio_wr_latch: req=%b addr=%h wdata=%h wstrb=%b, required 1 10000100 deadbeef 0011",
                     io_req, io_addr, io_wdata, io_wstrb);
        end
        io_ack = 1'b1;
        wait_ready(10, lat);
        io_ack = 1'b0;
        checks++;
        if (lat !== 1 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL mmio_wr_min_latency: lat_after_first_wait=%0d err=%b, required 1 0", lat, bus_err);
        end
        $display("mmio write 0x10000100: total latency=%0d", lat + 1);
    endtask

    task automatic test_stray_ack();
        io_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_ready !== 1'b0 || io_req !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: ready=%b io_req=%b err=%b, required 0 0 0", mem_ready, io_req, bus_err);
        end
        io_ack = 1'b0;
        $display("stray ack: ignored");
    endtask

    task automatic test_unmapped();
        int lat;
        start(32'h2000_0000, 32'h0, 4'h0);
        checks++;
        if (ram_ce !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_ce: ce=%b, required 0", ram_ce);
        end
        wait_ready(10, lat);
        checks++;
        if (lat !== 1 || mem_rdata !== 32'h0 || bus_err !== 1'b1 || io_req !== 1'b0) begin
            errors++;
            $display("FAIL unmapped: lat=%0d rdata=%h err=%b io_req=%b, required 1 0 1 0",
                     lat, mem_rdata, bus_err, io_req);
        end
        @(posedge clk); #1;
        checks++;
        if (bus_err !== 1'b0 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_pulse: err=%b ready=%b next cycle, required 0 0", bus_err, mem_ready);
        end
        $display("unmapped 0x20000000: lat=%0d", lat);
    endtask

`ifdef KIANV_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int bad = 0;
        start(32'h1000_0008, 32'h0, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (io_req !== 1'b1 || mem_ready !== 1'b0) bad++;
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;
        checks++;
        if (bad != 0 || io_req !== 1'b0 || mem_ready !== 1'b1 || mem_rdata !== 32'hFFFF_FFFF || bus_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout: bad_wait=%0d io_req=%b ready=%b rdata=%h err=%b, required 0 0 1 ffffffff 1",
                     bad, io_req, mem_ready, mem_rdata, bus_err);
        end
        $display("timeout 0x10000008: rdata=%h err=%b", mem_rdata, bus_err);
    endtask
`else
    task automatic test_no_timeout();
        int bad = 0;
        start(32'h1000_0008, 32'h0, 4'h0);
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); #1;
            if (io_req !== 1'b1 || mem_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_timeout: %0d cycles not pending, required 0", bad);
        end
        $display("no timeout: pending after 1000 cycles");
    endtask
`endif

    task automatic test_reset_mid_mmio();
        int lat;
        if (io_req !== 1'b1) begin
            start(32'h1000_000C, 32'h0, 4'h0);
            repeat (2) @(posedge clk);
        end
        #3;
        mem_valid = 1'b0;
        resetn = 1'b0;
        #1;
        checks++;
        if (io_req !== 1'b0 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mmio: io_req=%b ready=%b, required 0 0", io_req, mem_ready);
        end
        @(posedge clk); #1 resetn = 1'b1;
        start(32'h0000_0010, 32'h0, 4'h0);
        wait_ready(10, lat);
        checks++;
        if (lat !== 2 || mem_rdata !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL post_reset_read: lat=%0d rdata=%h, required 2 a5a51234", lat, mem_rdata);
        end
        $display("reset mid-mmio: post-reset read lat=%0d rdata=%h", lat, mem_rdata);
    endtask

    initial begin
        test_reset();
        test_ram_write_read();
        test_byte_write();
        test_mmio_read();
        test_mmio_write_min();
        test_stray_ack();
        test_unmapped();
`ifdef KIANV_BUS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_mmio();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kianv_bus_bridge.md
# kianv_bus_bridge

Memory-side bus bridge directly downstream of the kianV multicycle RV32IM core. Accepts the core's valid/ready memory request (valid, ready, wstrb, addr, wdata, rdata) and routes each access to either a synchronous single-port SRAM or a req/ack MMIO port. Registers the response data and the `mem_ready` pulse back to the core, and flags unmapped accesses. Optionally detects MMIO timeouts.

## Interface
Parameters:
- RAM_BASE, 32'h0000_0000, byte base address of the SRAM window; must be aligned to the window size.
- RAM_AW, 10, SRAM word-address width; window size is 4·2^RAM_AW bytes.
- MMIO_BASE, 32'h1000_0000, MMIO match value.
- MMIO_MASK, 32'hF000_0000, MMIO match mask.
- TIMEOUT_CYCLES, 255, number of MMIO wait cycles before abort (used only with KIANV_BUS_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid  in  1  core request valid; held until `mem_ready` is seen.
- mem_ready  out  1  one-cycle completion pulse.
- mem_wstrb  in  4  byte write strobes; 0 means read.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data; valid while `mem_ready`=1.
- ram_ce  out  1  SRAM chip enable.
- ram_we  out  4  SRAM byte write enables.
- ram_addr  out  RAM_AW  SRAM word address.
- ram_wdata  out  32  SRAM write data.
- ram_rdata  in  32  SRAM read data, valid the cycle after `ram_ce`.
- io_req  out  1  MMIO request, held until ack or abort.
- io_wstrb  out  4  MMIO byte strobes.
- io_addr  out  32  MMIO byte address.
- io_wdata  out  32  MMIO write data.
- io_ack  in  1  MMIO completion, sampled while `io_req`=1.
- io_rdata  in  32  MMIO read data, valid with `io_ack`.
- bus_err  out  1  one-cycle pulse coinciding with `mem_ready` on an unmapped or timed-out access.

## Operation
- Address decode in IDLE:
  - ram_hit = (mem_addr & ~(2^(RAM_AW+2)−1)) == RAM_BASE.
  - io_hit = (mem_addr & MMIO_MASK) == MMIO_BASE.
  - RAM takes priority when both match.
  - Anything else is unmapped.
- States: IDLE, RAM_RD, IO_WAIT, DONE.
- IDLE & mem_valid & ram_hit:
  - `ram_ce`=1, `ram_we`=mem_wstrb, `ram_addr`=mem_addr[RAM_AW+1:2], `ram_wdata`=mem_wdata. These drive combinationally, this cycle only.
  - On a write, go to DONE.
  - On a read, go to RAM_RD.
- RAM_RD: capture ram_rdata into the response register, then go to DONE.
- IDLE & mem_valid & io_hit:
  - Latch addr, wdata and wstrb into the io_* registers.
  - Set `io_req`=1 and go to IO_WAIT.
- IO_WAIT & io_ack:
  - Clear `io_req` and capture io_rdata (for writes too; the core ignores it).
  - Go to DONE.
- IDLE & mem_valid & unmapped: response data = 0, set the error flag, go to DONE.
- DONE: `mem_ready`=1 (registered), `mem_rdata`=response register, `bus_err`=error flag. Return to IDLE.
- `mem_valid` is ignored in every state except IDLE. The core drops or replaces its request after `mem_ready`, and the DONE→IDLE step guarantees no double issue.
- `ram_ce`=0 and `ram_we`=0 outside the IDLE-and-RAM-hit cycle.

## Timing
- Reset (asynchronous, active-low, takes effect mid-transaction):
  - State returns to IDLE.
  - `mem_ready`, `bus_err`, `io_req`, `io_wstrb`, `io_addr`, `io_wdata`, `mem_rdata` all reset to 0.
  - The counter resets to 0.
  - An MMIO access in flight is dropped with no response.
- Latency from the first IDLE cycle with mem_valid (T) to `mem_ready`:
  - RAM write: T+1.
  - RAM read: T+2.
  - Unmapped: T+1.
  - MMIO: `io_req` is high from T+1. If ack is sampled at cycle A, `mem_ready` is at A+1.
  - An ack in the first IO_WAIT cycle gives the minimum MMIO latency of T+2.
- Back-to-back issue: the earliest next request is accepted in the cycle after DONE.
- An `io_ack` arriving while `io_req`=0 is ignored.

## Configuration
- KIANV_BUS_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to IO_WAIT and increments every IO_WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES without ack, clear `io_req`, set response data to 32'hFFFF_FFFF, set the error flag, and go to DONE.
  - An ack in the same cycle the count is reached wins; that is a normal completion.
- KIANV_BUS_TIMEOUT_EN undefined: there is no counter, and IO_WAIT waits indefinitely for `io_ack`.

## Test plan
- RAM write, then read. Stimulus: write addr 0x0000_0010, wdata 0xA5A5_1234, wstrb 4'hF; then read the same address with the SRAM model returning the stored word. Required: `ram_we`=4'hF and `ram_addr`=4 at T; `mem_ready` at T+1. For the read, `mem_ready` at T+2 with `mem_rdata`=0xA5A5_1234.
- Byte write. Stimulus: wstrb 4'b0100 at addr 0x0000_0022. Required: `ram_we`=4'b0100, `ram_addr`=8, one `mem_ready` pulse.
- MMIO read with 5-cycle ack delay. Stimulus: addr 0x1000_0004, io_rdata 0xCAFE_F00D. Required: `io_req` held until ack; `mem_ready` one cycle after ack with `mem_rdata`=0xCAFE_F00D; `bus_err`=0.
- Unmapped. Stimulus: read at 0x2000_0000. Required: `mem_ready` at T+1, `mem_rdata`=0, `bus_err`=1 for one cycle; no `ram_ce`, no `io_req`.
- Timeout (macro on, TIMEOUT_CYCLES=4, no ack). Required: `io_req` drops after 4 wait cycles; `mem_rdata`=0xFFFF_FFFF, `bus_err`=1. With the macro off, the access remains pending for 1000 cycles.
- Reset mid-MMIO. Stimulus: assert resetn=0 while `io_req`=1. Required: `io_req`=0 and `mem_ready`=0 immediately; after release, a RAM read completes normally at T+2.
